fsm_dispensador: RTL and testbench

Dispensing sequencer that consumes a completed beverage selection (base, mix, extra) and drives the valve and heater outputs through a timed preparation sequence. It is the executing end of the selector: the selector decides *what* to make, this block decides *when* each actuator is on. Timing uses a one-cycle `Tick` enable (nominally one second) produced in the `CLK` domain. There is no second clock in this block.

---
 rtl/dispensador_pkg.sv | 17 +
 rtl/temporizador_fase.sv | 18 +
 rtl/fsm_dispensador.sv | 86 ++++++++
 tb/tb_fsm_dispensador.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dispensador_pkg.sv
// dispensador_pkg: state codes, default phase lengths in ticks and phase counter width
package dispensador_pkg;
  localparam int CNT_W = 4;
  localparam int T_CALENTAR_DEF = 3;
  localparam int T_BASE_DEF = 5;
  localparam int T_MEZCLA_DEF = 4;
  localparam int T_EXTRA_DEF = 2;
  localparam int T_LISTO_DEF = 3;
  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    CALENTAR = 3'd1,
    BASE     = 3'd2,
    MEZCLA   = 3'd3,
    EXTRA    = 3'd4,
    LISTO    = 3'd5
  } estado_t;
endpackage

// File: rtl/temporizador_fase.sv
// temporizador_fase: phase down-counter; ports clk, rst (async), carga/valor load, tick decrement, cuenta, fin = tick & cuenta==1
module temporizador_fase
  import dispensador_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             carga,
  input  logic [CNT_W-1:0] valor,
  input  logic             tick,
  output logic [CNT_W-1:0] cuenta,
  output logic             fin
);
  assign fin = tick && cuenta == CNT_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cuenta <= '0;
    else if (carga) cuenta <= valor;
    else if (tick && cuenta != '0) cuenta <= cuenta - 1'b1;
endmodule

// File: rtl/fsm_dispensador.sv
// fsm_dispensador: timed beverage sequencer; CLK, RESET (async), Tick, Pedido, Base/Mezcla/Extra recipe in, Cancelar (only with DISPENSADOR_CANCEL_EN), Moore valve/heater outputs, Ocupado, Listo, Estado, Restante
module fsm_dispensador
  import dispensador_pkg::*;
#(
  parameter int T_CALENTAR = T_CALENTAR_DEF,
  parameter int T_BASE     = T_BASE_DEF,
  parameter int T_MEZCLA   = T_MEZCLA_DEF,
  parameter int T_EXTRA    = T_EXTRA_DEF,
  parameter int T_LISTO    = T_LISTO_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Tick,
  input  logic             Pedido,
  input  logic             Base,
  input  logic             Mezcla,
  input  logic             Extra,
`ifdef DISPENSADOR_CANCEL_EN
  input  logic             Cancelar,
`endif
  output logic             ValvulaCafe,
  output logic             ValvulaTe,
  output logic             ValvulaLeche,
  output logic             ValvulaAgua,
  output logic             ValvulaVainilla,
  output logic             Calentador,
  output logic             Ocupado,
  output logic             Listo,
  output logic [2:0]       Estado,
  output logic [CNT_W-1:0] Restante
);
  estado_t estado, nxt;
  logic base_q, mezcla_q, extra_q, base_n, mezcla_n, extra_n, fin;
  logic [CNT_W-1:0] valor;
  function automatic logic [CNT_W-1:0] duracion(input estado_t s);
    return s == CALENTAR ? CNT_W'(T_CALENTAR) :
           s == BASE     ? CNT_W'(T_BASE) :
           s == MEZCLA   ? CNT_W'(T_MEZCLA) :
           s == EXTRA    ? CNT_W'(T_EXTRA) :
           s == LISTO    ? CNT_W'(T_LISTO) : '0;
  endfunction
  always_comb begin
    {base_n, mezcla_n, extra_n} = (estado == REPOSO && Pedido) ? {Base, Mezcla, Extra} : {base_q, mezcla_q, extra_q};
    case (estado)
      REPOSO:   nxt = Pedido ? CALENTAR : REPOSO;
      CALENTAR: nxt = fin ? BASE : CALENTAR;
      BASE:     nxt = fin ? MEZCLA : BASE;
      MEZCLA:   nxt = fin ? (extra_q ? EXTRA : LISTO) : MEZCLA;
      EXTRA:    nxt = fin ? LISTO : EXTRA;
      LISTO:    nxt = fin ? REPOSO : LISTO;
      default:  nxt = REPOSO;
    endcase
`ifdef DISPENSADOR_CANCEL_EN
    if (Cancelar && estado inside {CALENTAR, BASE, MEZCLA, EXTRA}) nxt = REPOSO;
`endif
    valor = duracion(nxt);
  end
  // any state change reloads the counter, so a coincident Tick never counts toward the new phase
  temporizador_fase u_tmp (
    .clk   (CLK),
    .rst   (RESET),
    .carga (nxt != estado),
    .valor (valor),
    .tick  (Tick),
    .cuenta(Restante),
    .fin   (fin)
  );
  assign Estado = estado;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      estado <= REPOSO;
      {base_q, mezcla_q, extra_q} <= '0;
      {ValvulaCafe, ValvulaTe, ValvulaLeche, ValvulaAgua, ValvulaVainilla, Calentador, Ocupado, Listo} <= '0;
    end else begin
      estado <= nxt;
      {base_q, mezcla_q, extra_q} <= {base_n, mezcla_n, extra_n};
      Calentador <= nxt == CALENTAR;
      ValvulaCafe <= nxt == BASE && !base_n;
      ValvulaTe <= nxt == BASE && base_n;
      ValvulaLeche <= nxt == MEZCLA && !mezcla_n;
      ValvulaAgua <= nxt == MEZCLA && mezcla_n;
      ValvulaVainilla <= nxt == EXTRA;
      Ocupado <= nxt != REPOSO;
      Listo <= nxt == LISTO;
    end
endmodule

// File: tb/tb_fsm_dispensador.sv
// tb_fsm_dispensador: directed and random checks of fsm_dispensador against an elapsed-tick reference model
module tb_fsm_dispensador;
  localparam int TC = 3, TB = 5, TM = 4, TE = 2, TL = 3;
  logic CLK = 0, RESET = 1, Tick = 0, Pedido = 0, Base = 0, Mezcla = 0, Extra = 0;
`ifdef DISPENSADOR_CANCEL_EN
  logic Cancelar = 0;
`endif
  logic ValvulaCafe, ValvulaTe, ValvulaLeche, ValvulaAgua, ValvulaVainilla, Calentador, Ocupado, Listo;
  logic [2:0] Estado;
  logic [3:0] Restante;
  int n_cmp = 0, n_err = 0;
  bit m_busy = 0, m_b = 0, m_m = 0, m_x = 0;
  int m_e = 0;
  always #5 CLK = ~CLK;
  fsm_dispensador dut (
    .CLK(CLK), .RESET(RESET), .Tick(Tick), .Pedido(Pedido), .Base(Base), .Mezcla(Mezcla), .Extra(Extra),
`ifdef DISPENSADOR_CANCEL_EN
    .Cancelar(Cancelar),
`endif
    .ValvulaCafe(ValvulaCafe), .ValvulaTe(ValvulaTe), .ValvulaLeche(ValvulaLeche), .ValvulaAgua(ValvulaAgua),
    .ValvulaVainilla(ValvulaVainilla), .Calentador(Calentador), .Ocupado(Ocupado), .Listo(Listo),
    .Estado(Estado), .Restante(Restante)
  );
  function automatic int total(input bit x);
    return TC + TB + TM + (x ? TE : 0) + TL;
  endfunction
  // phase and remaining ticks derived from ticks elapsed since the order edge
  task automatic ref_out(output logic [2:0] st, output logic [3:0] rs);
    int d[5];
    int acc;
    bit found;
    st = 0; rs = 0; acc = 0; found = 0;
    d = '{TC, TB, TM, (m_x ? TE : 0), TL};
    if (m_busy)
      for (int i = 0; i < 5; i++) begin
        if (!found && d[i] != 0 && m_e < acc + d[i]) begin
          st = 3'(i + 1); rs = 4'(acc + d[i] - m_e); found = 1;
        end
        acc += d[i];
      end
  endtask
  function automatic logic [7:0] ref_act(input logic [2:0] st);
    return {st == 3'd1, st == 3'd2 && !m_b, st == 3'd2 && m_b, st == 3'd3 && !m_m, st == 3'd3 && m_m,
            st == 3'd4, st != 3'd0, st == 3'd5};
  endfunction
  function automatic logic [7:0] dut_act();
    return {Calentador, ValvulaCafe, ValvulaTe, ValvulaLeche, ValvulaAgua, ValvulaVainilla, Ocupado, Listo};
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    logic [2:0] st;
    logic [3:0] rs;
    ref_out(st, rs);
    chk("estado", {5'b0, Estado}, {5'b0, st});
    chk("restante", {4'b0, Restante}, {4'b0, rs});
    chk("salidas", dut_act(), ref_act(st));
  endtask
  task automatic model_edge();
    logic [2:0] st;
    logic [3:0] rs;
    bit can;
    can = 0;
`ifdef DISPENSADOR_CANCEL_EN
    can = Cancelar;
`endif
    ref_out(st, rs);
    if (!m_busy) begin
      if (Pedido) begin
        m_busy = 1; m_e = 0; m_b = Base; m_m = Mezcla; m_x = Extra;
      end
    end else if (can && st != 3'd5) m_busy = 0;
    else if (Tick) begin
      m_e++;
      if (m_e == total(m_x)) m_busy = 0;
    end
  endtask
  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all();
  endtask
  task automatic cyc(input bit t);
    Tick = t;
    step();
  endtask
  task automatic order(input bit b, input bit m, input bit x, input bit t);
    {Base, Mezcla, Extra} = {b, m, x};
    Pedido = 1;
    cyc(t);
    Pedido = 0;
  endtask
  task automatic run_to_idle(input int per, input bit tog, output int nt);
    nt = 0;
    for (int i = 0; i < 600 && m_busy; i++) begin
      bit t;
      t = (i % per) == per - 1;
      if (t) nt++;
      if (tog) {Base, Mezcla, Extra} = 3'($urandom);
      cyc(t);
    end
    chk("fin_orden", {7'b0, Ocupado}, 8'd0);
  endtask
  initial begin
    int nt;
    logic [2:0] st;
    logic [3:0] rs;
    repeat (2) @(negedge CLK);
    check_all();
    RESET = 0;
    order(0, 0, 0, 0);
    run_to_idle(10, 0, nt);
    chk("ticks_cafe_leche", 8'(nt), 8'd15);
    order(1, 1, 1, 0);
    run_to_idle(10, 1, nt);
    chk("ticks_te_agua_vainilla", 8'(nt), 8'd17);
    order(0, 1, 0, 0);
    for (int i = 0; i < 600 && m_busy; i++) begin
      ref_out(st, rs);
      Pedido = (st == 3'd5) ? 1'b1 : (st == 3'd3 && $urandom_range(1) == 1);
      cyc(i % 3 == 2);
    end
    cyc(0);
    chk("reinicio_pedido", {5'b0, Estado}, 8'd1);
    Pedido = 0;
    run_to_idle(2, 0, nt);
    order(0, 0, 1, 1);
    chk("carga_con_tick", {4'b0, Restante}, 8'(TC));
    cyc(0);
    cyc(1);
    chk("primer_decremento", {4'b0, Restante}, 8'(TC - 1));
    run_to_idle(1, 0, nt);
    order(0, 0, 0, 0);
    for (int i = 0; i < 40 && m_e < TC + 2; i++) cyc(1);
    chk("cafe_antes_reset", {7'b0, ValvulaCafe}, 8'd1);
    RESET = 1;
    #1;
    m_busy = 0;
    check_all();
    #2 RESET = 0;
    cyc(1);
`ifdef DISPENSADOR_CANCEL_EN
    order(0, 0, 0, 0);
    cyc(1);
    chk("restante_cancel", {4'b0, Restante}, 8'd2);
    Cancelar = 1;
    cyc(0);
    Cancelar = 0;
    chk("cancel_estado", {5'b0, Estado}, 8'd0);
    chk("cancel_salidas", dut_act(), 8'd0);
    order(1, 0, 1, 0);
    for (int i = 0; i < 40 && Estado != 3'd5; i++) cyc(1);
    Cancelar = 1;
    cyc(0);
    Cancelar = 0;
    chk("cancel_listo", {5'b0, Estado}, 8'd5);
    run_to_idle(1, 0, nt);
`endif
    for (int i = 0; i < 1500; i++) begin
      Pedido = $urandom_range(4) == 0;
      {Base, Mezcla, Extra} = 3'($urandom);
`ifdef DISPENSADOR_CANCEL_EN
      Cancelar = $urandom_range(24) == 0;
`endif
      cyc($urandom_range(2) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
